// File: rtl/acc_data_fifo.sv
// Single-clock FIFO between the router and an accelerator core: registered read
// data with a one-cycle valid strobe, occupancy count, almost-full and sticky error flags.
module acc_data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  put_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  get_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DepthC = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfC    = AF_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_en, rd_en;

  assign full        = (count_q == DepthC);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AfC);

  // There is no ready back-pressure: put/get are one-cycle requests, and acceptance is
  // decided here from the registered count. A put into a full FIFO is still taken when a
  // get frees a slot on the same edge; a get from an empty FIFO is never written through.
  assign wr_en = put_req & (~full | get_req);
  assign rd_en = get_req & ~empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        data_out_d   = mem[rd_ptr_q];
        data_valid_d = 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (put_req & full & ~get_req) overflow_d = 1'b1;
      if (get_req & empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain register arrays.
  always_ff @(posedge clk) begin
    if (!flush && wr_en) mem[wr_ptr_q] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_acc_data_fifo.sv
// Randomised and directed bench for acc_data_fifo against a queue-based reference model;
// popped words go through an expected queue checked by an independent monitor.
module tb_acc_data_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 12;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          put_req;
  logic [DW-1:0] data_in;
  logic          get_req;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  acc_data_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .put_req(put_req), .data_in(data_in), .get_req(get_req),
    .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    int sz;
    sz = model_q.size();
    chk("count",       DW'(count),       DW'(sz));
    chk("empty",       DW'(empty),       DW'(sz == 0));
    chk("full",        DW'(full),        DW'(sz == DEPTH));
    chk("almost_full", DW'(almost_full), DW'(sz >= AF));
    chk("overflow",    DW'(overflow),    DW'(m_ovf));
    chk("underflow",   DW'(underflow),   DW'(m_unf));
    chk("data_valid",  DW'(data_valid),  DW'(m_valid));
    chk("data_out",    data_out,         m_out);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Driver: apply one cycle of requests, advance the model on the same edge, check flags.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic g, input logic f);
    bit do_rd, do_wr;
    put_req = p;
    data_in = d;
    get_req = g;
    flush   = f;
    @(posedge clk);
    if (f) begin
      model_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      do_rd   = g && (model_q.size() > 0);
      do_wr   = p && ((model_q.size() < DEPTH) || g);
      m_valid = do_rd;
      if (do_rd) begin
        m_out = model_q.pop_front();
        exp_q.push_back(m_out);
      end
      if (do_wr) model_q.push_back(d);
      if (p && !do_wr) m_ovf = 1'b1;
      if (g && !do_rd) m_unf = 1'b1;
    end
    #1;
    put_req = 1'b0;
    get_req = 1'b0;
    flush   = 1'b0;
    chk_outputs();
  endtask

  // Monitor / scoreboard: every data_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && data_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_data: got 0x%0h with data_valid, expected no pop", data_out);
      end else begin
        chk("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b0;
    put_req = 1'b0;
    get_req = 1'b0;
    flush   = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    chk_outputs();

    // Fill with 0x100..0x10F, watching almost_full and full
    for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    chk("full_after_fill", DW'(full), DW'(1));

    // Overflow: dropped put
    step(1'b1, DW'(32'hDEAD), 1'b0, 1'b0);
    chk("overflow_set", DW'(overflow), DW'(1));
    chk("count_at_ovf", DW'(count), DW'(16));

    // Full with simultaneous put+get
    step(1'b1, DW'(32'h200), 1'b1, 1'b0);
    chk("count_full_pg", DW'(count), DW'(16));

    // Drain everything
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("empty_after_drain", DW'(empty), DW'(1));

    // Empty with simultaneous put+get
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, DW'(32'hA5A5), 1'b1, 1'b0);
    chk("underflow_set", DW'(underflow), DW'(1));
    chk("count_after_unf", DW'(count), DW'(1));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("a5a5_pop", data_out, DW'(32'hA5A5));

    // 40 words through with random gets, wrapping the pointers
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, ($urandom_range(0, 2) != 0), 1'b0);
    while (model_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);

    // 5 queued with overflow set, then flush together with a put
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("five_queued", DW'(count), DW'(5));
    chk("ovf_before_flush", DW'(overflow), DW'(1));
    step(1'b1, DW'(32'hBEEF), 1'b0, 1'b1);
    chk("count_after_flush", DW'(count), DW'(0));
    chk("empty_after_flush", DW'(empty), DW'(1));
    chk("ovf_after_flush", DW'(overflow), DW'(0));

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 2));

    // Reset asserted mid-burst: outputs clear asynchronously
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk("exp_q_drained", DW'(exp_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
